// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive front end of the terminal UART.
// Deserialises the 8N1 serial line from the FT2232 and buffers the received
// bytes in a first-word-fall-through FIFO. Sticky status flags record
// overruns and framing errors.
//
// Ports:
//   clk           oscillator clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   i_UART_TX     asynchronous serial input, idle high
//   i_rd          one-cycle pop strobe
//   i_clr_err     one-cycle strobe clearing the sticky error flags
//   o_data        FIFO head byte, valid while o_rx_ready=1
//   o_rx_ready    FIFO not empty
//   o_full        FIFO holds 2**FIFO_AW bytes
//   o_count       number of bytes held
//   o_overrun     sticky: byte arrived while FIFO full
//   o_framing_err sticky: stop bit sampled low
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 385,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_UART_TX,
   input  logic               i_rd,
   input  logic               i_clr_err,
   output logic [7:0]         o_data,
   output logic               o_rx_ready,
   output logic               o_full,
   output logic [FIFO_AW:0]   o_count,
   output logic               o_overrun,
   output logic               o_framing_err
);

   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [TW-1:0]    HALF_C  = TW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0]    LAST_C  = TW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   logic                sync1_r;
   logic                rx_s;
   state_t              state_r, state_nxt_s;
   logic [TW-1:0]       timer_r, timer_nxt_s;
   logic [2:0]          bit_idx_r, bit_idx_nxt_s;
   logic [7:0]          shift_r, shift_nxt_s;
   logic                push_s;
   logic                frame_err_s;

   logic [7:0]          mem_r [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_r, rd_ptr_r;
   logic [FIFO_AW:0]    count_r, count_nxt_s;
   logic                full_r, ready_r, overrun_r, framing_r;
   logic                pop_s, push_ok_s, ovr_set_s;

   // Two-flop synchroniser on the asynchronous serial line (resets to idle high).
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync1_r <= i_UART_TX;
         rx_s    <= sync1_r;
      end
   end

   // Receiver state, bit timer, bit index and shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         timer_r   <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
      end else begin
         state_r   <= state_nxt_s;
         timer_r   <= timer_nxt_s;
         bit_idx_r <= bit_idx_nxt_s;
         shift_r   <= shift_nxt_s;
      end
   end

   // Receiver next-state logic; the timer restarts from zero on every state entry.
   always_comb begin
      state_nxt_s   = state_r;
      timer_nxt_s   = timer_r + TW'(1);
      bit_idx_nxt_s = bit_idx_r;
      shift_nxt_s   = shift_r;
      push_s        = 1'b0;
      frame_err_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            timer_nxt_s = '0;
            if (!rx_s) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            // Re-check the line in the middle of the start bit to reject glitches.
            if (timer_r == HALF_C) begin
               timer_nxt_s = '0;
               if (!rx_s) begin
                  state_nxt_s   = ST_DATA;
                  bit_idx_nxt_s = 3'd0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (timer_r == LAST_C) begin
               timer_nxt_s = '0;
               shift_nxt_s = {rx_s, shift_r[7:1]};   // LSB arrives first
               if (bit_idx_r == 3'd7) begin
                  state_nxt_s = ST_STOP;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 3'd1;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (timer_r == LAST_C) begin
               timer_nxt_s = '0;
               if (rx_s) begin
                  push_s      = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  frame_err_s = 1'b1;
                  state_nxt_s = ST_BREAK;
               end
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            // Wait out a held-low line so it reports only one framing error.
            timer_nxt_s = '0;
            if (rx_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_BREAK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = '0;
         end
      endcase
   end

   // FIFO control: a pop frees a slot, so push+pop on a full FIFO is not an overrun.
   always_comb begin
      pop_s       = i_rd && (count_r != '0);
      push_ok_s   = push_s && ((count_r != DEPTH_C) || pop_s);
      ovr_set_s   = push_s && !push_ok_s;
      count_nxt_s = count_r;
      case ({push_ok_s, pop_s})
         2'b10:   count_nxt_s = count_r + {{FIFO_AW{1'b0}}, 1'b1};
         2'b01:   count_nxt_s = count_r - {{FIFO_AW{1'b0}}, 1'b1};
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO storage, pointers, status registers and sticky error flags (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         full_r    <= 1'b0;
         ready_r   <= 1'b0;
         overrun_r <= 1'b0;
         framing_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= shift_r;
            wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
         end
         count_r   <= count_nxt_s;
         full_r    <= (count_nxt_s == DEPTH_C);
         ready_r   <= (count_nxt_s != '0);
         overrun_r <= ovr_set_s   | (overrun_r & ~i_clr_err);
         framing_r <= frame_err_s | (framing_r & ~i_clr_err);
      end
   end

   assign o_data        = mem_r[rd_ptr_r];
   assign o_rx_ready    = ready_r;
   assign o_full        = full_r;
   assign o_count       = count_r;
   assign o_overrun     = overrun_r;
   assign o_framing_err = framing_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard (CLKS_PER_BIT=8).
module tb_uart_rx_fifo;

   localparam int CPB = 8;
   localparam int AW  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          tx;
   logic          rd;
   logic          clr;
   logic [7:0]    o_data;
   logic          o_rx_ready;
   logic          o_full;
   logic [AW:0]   o_count;
   logic          o_overrun;
   logic          o_framing_err;

   int            vectors     = 0;
   int            miscompares = 0;
   logic [7:0]    exp_q [$];
   logic          exp_ovr;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .clk(clk),
      .reset(reset),
      .i_UART_TX(tx),
      .i_rd(rd),
      .i_clr_err(clr),
      .o_data(o_data),
      .o_rx_ready(o_rx_ready),
      .o_full(o_full),
      .o_count(o_count),
      .o_overrun(o_overrun),
      .o_framing_err(o_framing_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "/count"},   32'(o_count),    32'(exp_q.size()));
      check({tag, "/ready"},   32'(o_rx_ready), 32'(exp_q.size() != 0));
      check({tag, "/full"},    32'(o_full),     32'(exp_q.size() == 16));
      check({tag, "/overrun"}, 32'(o_overrun),  32'(exp_ovr));
   endtask

   // Drive one 8N1 frame; optional rd/clr strobes land on the stop-sample cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input logic rd_at_stop, input logic clr_at_stop);
      logic [7:0] popped;
      tx = 1'b0;
      repeat (CPB) tick();
      for (int j = 0; j < 8; j++) begin
         tx = b[j];
         repeat (CPB) tick();
      end
      tx = stop_bit;
      for (int i = 0; i < CPB; i++) begin
         if (i == CPB - 1) begin
            if (rd_at_stop) begin
               check("stop_rd_head", 32'(o_data), 32'(exp_q[0]));
            end
            rd  = rd_at_stop;
            clr = clr_at_stop;
         end
         tick();
      end
      rd  = 1'b0;
      clr = 1'b0;
      if (stop_bit) begin
         if (rd_at_stop && exp_q.size() > 0) begin
            popped = exp_q.pop_front();
         end
         if (exp_q.size() < 16) begin
            exp_q.push_back(b);
         end else begin
            exp_ovr = 1'b1;
         end
         repeat (2) tick();
      end
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      e = 8'h00;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
      end
      check({tag, "/ready"}, 32'(o_rx_ready), 32'd1);
      check({tag, "/data"},  32'(o_data),     32'(e));
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      tx      = 1'b1;
      rd      = 1'b0;
      clr     = 1'b0;
      exp_ovr = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (50) tick();
      check_status("reset");
      check("reset/data",    32'(o_data),        32'h00);
      check("reset/framing", 32'(o_framing_err), 32'd0);

      // Single byte, then pop back to empty.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check_status("a5_rx");
      check("a5_data", 32'(o_data), 32'hA5);
      pop_check("a5_pop");
      check_status("a5_empty");

      // Read while empty is ignored.
      rd = 1'b1;
      tick();
      rd = 1'b0;
      tick();
      check_status("rd_empty");

      // Two-cycle low glitch is rejected.
      tx = 1'b0;
      repeat (2) tick();
      tx = 1'b1;
      repeat (20) tick();
      check_status("glitch");
      check("glitch/framing", 32'(o_framing_err), 32'd0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      check_status("3c_rx");
      pop_check("3c_pop");

      // Fill to 16, 17th overruns, drain across the pointer wrap.
      for (int k = 0; k < 16; k++) begin
         send_frame(8'(k), 1'b1, 1'b0, 1'b0);
      end
      check_status("full16");
      send_frame(8'h10, 1'b1, 1'b0, 1'b0);
      check_status("overrun17");
      for (int k = 0; k < 16; k++) begin
         pop_check("drain16");
      end
      check_status("drained");
      clr = 1'b1;
      tick();
      clr = 1'b0;
      exp_ovr = 1'b0;
      check_status("ovr_clr");

      // Full FIFO with a pop on the stop-sample cycle: no overrun.
      for (int k = 0; k < 16; k++) begin
         send_frame(8'h80 + 8'(k), 1'b1, 1'b0, 1'b0);
      end
      check_status("refill");
      send_frame(8'h77, 1'b1, 1'b1, 1'b0);
      check_status("full_pushpop");
      for (int k = 0; k < 16; k++) begin
         pop_check("drain_77");
      end
      check_status("drained_77");

      // Bad stop bit with a clear on the same cycle: set wins; held low gives one error.
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      check("ferr_set", 32'(o_framing_err), 32'd1);
      check_status("ferr_nopush");
      repeat (10) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (20) tick();
      check("ferr_once", 32'(o_framing_err), 32'd0);
      tx = 1'b1;
      repeat (20) tick();
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      check_status("12_rx");
      pop_check("12_pop");

      // Reset in the middle of a frame with a byte buffered.
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      check_status("5a_rx");
      tx = 1'b0;
      repeat (CPB) tick();
      tx = 1'b1;
      repeat (CPB) tick();
      tx = 1'b0;
      repeat (CPB) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tx    = 1'b1;
      exp_q.delete();
      exp_ovr = 1'b0;
      repeat (100) tick();
      check_status("midreset");
      check("midreset/data",    32'(o_data),        32'h00);
      check("midreset/framing", 32'(o_framing_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive front end of the 6809 terminal UART, upstream of uart_interface.
- Deserialises the FT2232 TX line (i_UART_TX) into bytes and buffers them in a first-word-fall-through FIFO.
- Exposes head byte, ready/count, and sticky error status for the data and status registers.
- Runs on the internal 44.33 MHz oscillator clock.

Parameters:
CLKS_PER_BIT, 385, clk cycles per bit (44.33 MHz / 115200); minimum 4
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16

Ports:
clk  input  1  internal oscillator clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
i_UART_TX  input  1  asynchronous serial line from FT2232; idle high
i_rd  input  1  one-cycle pop strobe (6809 read of data register)
i_clr_err  input  1  one-cycle strobe clearing sticky error flags
o_data  output  8  FIFO head byte; valid while o_rx_ready=1
o_rx_ready  output  1  FIFO not empty
o_full  output  1  FIFO holds 2**FIFO_AW bytes
o_count  output  FIFO_AW+1  bytes currently held
o_overrun  output  1  sticky: a byte was received while FIFO full
o_framing_err  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; synchroniser flops = 1; FIFO emptied.
  - o_data=0, o_rx_ready=0, o_full=0, o_count=0, o_overrun=0, o_framing_err=0.
  - Reset mid-frame abandons the partial byte; no push.
- Input sync: 2-flop synchroniser on i_UART_TX. All FSM decisions use the synchronised value rx_s.
- Bit timer:
  - Counter 0..CLKS_PER_BIT-1, reloaded on every state entry.
  - Mid-start sample at count CLKS_PER_BIT/2 (integer divide).
  - Later samples every CLKS_PER_BIT cycles after that.
- FSM states:
  - IDLE: rx_s=0 -> START, timer cleared.
  - START: at half-bit, rx_s=0 -> DATA with bit index 0; rx_s=1 -> IDLE (glitch rejected, no flag).
  - DATA: every full bit period, shift rx_s into the shift register LSB-first. After bit index 7 -> STOP.
  - STOP: one full bit period later, sample rx_s.
    - rx_s=1: push byte -> IDLE.
    - rx_s=0: set o_framing_err, discard byte -> BREAK.
  - BREAK: stay until rx_s=1, then -> IDLE. A held-low line yields exactly one framing error.
- Latency: byte is pushed on the stop-sample cycle. o_rx_ready and o_data update the next cycle. Start edge to push is 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles.
- FIFO:
  - Circular buffer with FIFO_AW-bit wrapping pointers plus separate count.
  - o_data = mem[rd_ptr], fall-through, registered memory read not required.
  - Pop when i_rd=1 and count>0: rd_ptr++, count--.
  - i_rd while empty: ignored; pointers unchanged, no error.
  - Push when count<depth: mem[wr_ptr]=byte, wr_ptr++, count++.
  - Push when full with no pop the same cycle: byte dropped, o_overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle:
    - Count unchanged. When full this is legal: pop frees the slot, so no overrun.
    - When empty, push only; the pop is ignored and count becomes 1.
  - Pointers wrap 2**FIFO_AW-1 -> 0.
- o_full = (count == 2**FIFO_AW).
- Errors:
  - o_overrun and o_framing_err are sticky until i_clr_err.
  - A set and a clear in the same cycle: set wins.
  - Errors never block reception.

Test Plan:
- CLKS_PER_BIT=8. After reset, idle line for 50 cycles -> o_rx_ready=0, o_count=0, all flags 0.
- Send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> o_rx_ready=1, o_data=0xA5, o_count=1. Then i_rd pulse -> o_rx_ready=0, o_count=0.
- Low glitch of 2 cycles on idle line -> FSM returns to IDLE, no push, no flag. Then send 0x3C -> o_data=0x3C.
- Send 17 bytes 0x00..0x10 with no reads:
  - After 16: o_full=1, o_count=16.
  - 17th byte: o_overrun=1, count stays 16.
  - 16 pops return 0x00..0x0F in order, across the pointer wrap.
- FIFO full, i_rd asserted on the exact stop-sample cycle of a new byte 0x77 -> no overrun, count stays 16, 0x77 read last.
- Frame 0x55 with stop bit 0, line held low 30 cycles:
  - o_framing_err=1 once, no push.
  - Line returns high, then send 0x12 -> received correctly.
  - i_clr_err -> o_framing_err=0.
  - Reset asserted mid-frame -> all outputs 0, nothing pushed.
